// File: rtl/alarm_trigger_if.sv
// Alarm trigger bus: clock/alarm BCD digits, control pulses and ring status.
// master drives time, alarm and buttons; slave is the alarm_trigger block.
// No handshake: inputs are sampled every clk, outputs are registered levels.
interface alarm_trigger_if;
  logic       tick_1hz;
  logic       alarm_en;
  logic       stop_btn;
  logic       snooze_btn;
  logic [3:0] t_h_tens;
  logic [3:0] t_h_ones;
  logic [3:0] t_m_tens;
  logic [3:0] t_m_ones;
  logic [3:0] a_h_tens;
  logic [3:0] a_h_ones;
  logic [3:0] a_m_tens;
  logic [3:0] a_m_ones;
  logic       buzzer;
  logic       ringing;
  logic       snoozing;
  logic [1:0] snooze_cnt;

  modport master (
    output tick_1hz, alarm_en, stop_btn, snooze_btn,
    output t_h_tens, t_h_ones, t_m_tens, t_m_ones,
    output a_h_tens, a_h_ones, a_m_tens, a_m_ones,
    input  buzzer, ringing, snoozing, snooze_cnt
  );

  modport slave (
    input  tick_1hz, alarm_en, stop_btn, snooze_btn,
    input  t_h_tens, t_h_ones, t_m_tens, t_m_ones,
    input  a_h_tens, a_h_ones, a_m_tens, a_m_ones,
    output buzzer, ringing, snoozing, snooze_cnt
  );
endinterface

// File: rtl/alarm_trigger.sv
// Alarm trigger: compares HH:MM alarm with running time, rings the buzzer, handles stop/timeout/snooze.
// Latency: outputs registered, valid one clk after the triggering input; trigger fires on match rising edge.
// No backpressure; ALARM_SNOOZE_EN enables the SNOOZE state, otherwise snooze_btn behaves as stop_btn.
module alarm_trigger #(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_MINUTES = 5,
  parameter int MAX_SNOOZE     = 3
) (
  input logic           clk,
  input logic           rst,
  alarm_trigger_if.slave bus
);

  localparam int RING_W = $clog2(RING_SECONDS + 1);

`ifdef ALARM_SNOOZE_EN
  localparam int         SNZ_TICKS = SNOOZE_MINUTES * 60;
  localparam int         SNZ_W     = $clog2(SNZ_TICKS + 1);
  localparam logic [1:0] MAX_CNT   = 2'(MAX_SNOOZE);
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1
`ifdef ALARM_SNOOZE_EN
    ,
    SNOOZE  = 2'd2
`endif
  } state_t;

  state_t              state;
  logic [RING_W-1:0]   ring_cnt;
  logic                beep;
  logic                buzzer_q;
  logic                ringing_q;
  logic                match;
  logic                match_q;
  logic                trig;
  logic                stop_req;

`ifdef ALARM_SNOOZE_EN
  logic [SNZ_W-1:0]    snz_cnt;
  logic                snoozing_q;
  logic [1:0]          snooze_cnt_q;
`endif

  // Time equals alarm on all four BCD digits
  assign match = (bus.t_h_tens == bus.a_h_tens) && (bus.t_h_ones == bus.a_h_ones) &&
                 (bus.t_m_tens == bus.a_m_tens) && (bus.t_m_ones == bus.a_m_ones);

  // Fire only on the first clk of a match so a stopped alarm stays quiet for the rest of the minute
  assign trig = bus.alarm_en & match & ~match_q;

`ifdef ALARM_SNOOZE_EN
  assign stop_req = bus.stop_btn;
`else
  assign stop_req = bus.stop_btn | bus.snooze_btn;
`endif

  // Previous-cycle match for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) match_q <= 1'b0;
    else     match_q <= match;
  end

  // Alarm state machine with registered outputs; priority: enable, stop, snooze, expiry, tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ring_cnt  <= '0;
      beep      <= 1'b0;
      buzzer_q  <= 1'b0;
      ringing_q <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      snz_cnt      <= '0;
      snoozing_q   <= 1'b0;
      snooze_cnt_q <= 2'd0;
`endif
    end else if (!bus.alarm_en) begin
      state     <= IDLE;
      ring_cnt  <= '0;
      beep      <= 1'b0;
      buzzer_q  <= 1'b0;
      ringing_q <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      snz_cnt      <= '0;
      snoozing_q   <= 1'b0;
      snooze_cnt_q <= 2'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (trig) begin
            state     <= RINGING;
            ring_cnt  <= '0;
            beep      <= 1'b1;
            buzzer_q  <= 1'b1;
            ringing_q <= 1'b1;
`ifdef ALARM_SNOOZE_EN
            snz_cnt      <= '0;
            snoozing_q   <= 1'b0;
            snooze_cnt_q <= 2'd0;
`endif
          end
        end

        RINGING: begin
          if (stop_req) begin
            state     <= IDLE;
            ring_cnt  <= '0;
            beep      <= 1'b0;
            buzzer_q  <= 1'b0;
            ringing_q <= 1'b0;
          end
`ifdef ALARM_SNOOZE_EN
          else if (bus.snooze_btn) begin
            ring_cnt  <= '0;
            beep      <= 1'b0;
            buzzer_q  <= 1'b0;
            ringing_q <= 1'b0;
            if (snooze_cnt_q < MAX_CNT) begin
              state        <= SNOOZE;
              snz_cnt      <= '0;
              snoozing_q   <= 1'b1;
              snooze_cnt_q <= snooze_cnt_q + 2'd1;
            end else begin
              // Snooze budget exhausted: behave as stop
              state <= IDLE;
            end
          end
`endif
          else if (bus.tick_1hz) begin
            if (ring_cnt == RING_W'(RING_SECONDS - 1)) begin
              state     <= IDLE;
              ring_cnt  <= '0;
              beep      <= 1'b0;
              buzzer_q  <= 1'b0;
              ringing_q <= 1'b0;
            end else begin
              ring_cnt <= ring_cnt + RING_W'(1);
              beep     <= ~beep;
              buzzer_q <= ~beep;
            end
          end
        end

`ifdef ALARM_SNOOZE_EN
        SNOOZE: begin
          if (bus.stop_btn) begin
            state      <= IDLE;
            snz_cnt    <= '0;
            snoozing_q <= 1'b0;
          end else if (bus.tick_1hz) begin
            if (snz_cnt == SNZ_W'(SNZ_TICKS - 1)) begin
              state      <= RINGING;
              snz_cnt    <= '0;
              snoozing_q <= 1'b0;
              ring_cnt   <= '0;
              beep       <= 1'b1;
              buzzer_q   <= 1'b1;
              ringing_q  <= 1'b1;
            end else begin
              snz_cnt <= snz_cnt + SNZ_W'(1);
            end
          end
        end
`endif

        default: begin
          state     <= IDLE;
          ring_cnt  <= '0;
          beep      <= 1'b0;
          buzzer_q  <= 1'b0;
          ringing_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.buzzer  = buzzer_q;
  assign bus.ringing = ringing_q;

`ifdef ALARM_SNOOZE_EN
  assign bus.snoozing   = snoozing_q;
  assign bus.snooze_cnt = snooze_cnt_q;
`else
  assign bus.snoozing   = 1'b0;
  assign bus.snooze_cnt = 2'd0;

  // Snooze sizing has no effect without the snooze path
  logic unused_cfg;
  assign unused_cfg = (SNOOZE_MINUTES > 0) ^ (MAX_SNOOZE > 0);
`endif

endmodule

// File: tb/tb_alarm_trigger.sv
// Directed bench for alarm_trigger: vector table plus hand sequences for snooze, timeout and reset.
module tb_alarm_trigger;

  logic clk = 1'b0;
  logic rst;

  alarm_trigger_if bus();

  alarm_trigger #(
    .RING_SECONDS  (4),
    .SNOOZE_MINUTES(1),
    .MAX_SNOOZE    (3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        en;
    logic [15:0] t;
    logic        tick;
    logic        stop;
    logic        snz;
    logic        ring;
    logic        buz;
  } vec_t;

  vec_t vecs[26];

  function automatic vec_t mk(input logic en, input logic [15:0] t, input logic tk,
                              input logic sp, input logic sz, input logic rg, input logic bz);
    vec_t v;
    v.en = en; v.t = t; v.tick = tk; v.stop = sp; v.snz = sz; v.ring = rg; v.buz = bz;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_time(input logic [15:0] t);
    bus.t_h_tens = t[15:12];
    bus.t_h_ones = t[11:8];
    bus.t_m_tens = t[7:4];
    bus.t_m_ones = t[3:0];
  endtask

  // One clk with the given pulses; returns at the following negedge
  task automatic cyc(input logic tk, input logic sp, input logic sz);
    bus.tick_1hz   = tk;
    bus.stop_btn   = sp;
    bus.snooze_btn = sz;
    @(negedge clk);
    bus.tick_1hz   = 1'b0;
    bus.stop_btn   = 1'b0;
    bus.snooze_btn = 1'b0;
  endtask

  // Leave the matching minute and re-enter it to fire a fresh alarm
  task automatic retrig(input string nm);
    set_time(16'h0731);
    cyc(1'b0, 1'b0, 1'b0);
    set_time(16'h0730);
    cyc(1'b0, 1'b0, 1'b0);
    chk({nm, " ringing"}, {7'd0, bus.ringing}, 8'd1);
  endtask

  initial begin
    // Test 1: fire at 07:30, buzzer toggles per tick, stop
    vecs[0]  = mk(1, 16'h0729, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 16'h0730, 0, 0, 0, 1, 1);
    vecs[2]  = mk(1, 16'h0730, 1, 0, 0, 1, 0);
    vecs[3]  = mk(1, 16'h0730, 1, 0, 0, 1, 1);
    vecs[4]  = mk(1, 16'h0730, 0, 0, 0, 1, 1);
    vecs[5]  = mk(1, 16'h0730, 0, 1, 0, 0, 0);
    // Test 3: auto-off after RING_SECONDS=4 ticks, no re-fire in the same minute
    vecs[6]  = mk(1, 16'h0731, 0, 0, 0, 0, 0);
    vecs[7]  = mk(1, 16'h0730, 0, 0, 0, 1, 1);
    vecs[8]  = mk(1, 16'h0730, 1, 0, 0, 1, 0);
    vecs[9]  = mk(1, 16'h0730, 1, 0, 0, 1, 1);
    vecs[10] = mk(1, 16'h0730, 1, 0, 0, 1, 0);
    vecs[11] = mk(1, 16'h0730, 1, 0, 0, 0, 0);
    vecs[12] = mk(1, 16'h0730, 1, 0, 0, 0, 0);
    // Stop and snooze together: stop wins
    vecs[13] = mk(1, 16'h0731, 0, 0, 0, 0, 0);
    vecs[14] = mk(1, 16'h0730, 0, 0, 0, 1, 1);
    vecs[15] = mk(1, 16'h0730, 0, 1, 1, 0, 0);
    // Disabled alarm blocks trigger; enabling inside the minute does not fire
    vecs[16] = mk(0, 16'h0731, 0, 0, 0, 0, 0);
    vecs[17] = mk(0, 16'h0730, 0, 0, 0, 0, 0);
    vecs[18] = mk(1, 16'h0730, 0, 0, 0, 0, 0);
    // Disable while ringing
    vecs[19] = mk(1, 16'h0731, 0, 0, 0, 0, 0);
    vecs[20] = mk(1, 16'h0730, 0, 0, 0, 1, 1);
    vecs[21] = mk(0, 16'h0730, 0, 0, 0, 0, 0);
    // One digit off does not match
    vecs[22] = mk(1, 16'h0731, 0, 0, 0, 0, 0);
    vecs[23] = mk(1, 16'h1730, 0, 0, 0, 0, 0);
    vecs[24] = mk(1, 16'h0730, 0, 0, 0, 1, 1);
    vecs[25] = mk(1, 16'h0730, 0, 1, 0, 0, 0);

    rst            = 1'b1;
    bus.alarm_en   = 1'b1;
    bus.tick_1hz   = 1'b0;
    bus.stop_btn   = 1'b0;
    bus.snooze_btn = 1'b0;
    bus.a_h_tens   = 4'd0;
    bus.a_h_ones   = 4'd7;
    bus.a_m_tens   = 4'd3;
    bus.a_m_ones   = 4'd0;
    set_time(16'h0729);

    @(negedge clk);
    @(negedge clk);
    chk("reset buzzer",     {7'd0, bus.buzzer},   8'd0);
    chk("reset ringing",    {7'd0, bus.ringing},  8'd0);
    chk("reset snoozing",   {7'd0, bus.snoozing}, 8'd0);
    chk("reset snooze_cnt", {6'd0, bus.snooze_cnt}, 8'd0);
    rst = 1'b0;

    for (int i = 0; i < 26; i++) begin
      bus.alarm_en = vecs[i].en;
      set_time(vecs[i].t);
      cyc(vecs[i].tick, vecs[i].stop, vecs[i].snz);
      chk($sformatf("vec%0d ringing", i),    {7'd0, bus.ringing},    {7'd0, vecs[i].ring});
      chk($sformatf("vec%0d buzzer", i),     {7'd0, bus.buzzer},     {7'd0, vecs[i].buz});
      chk($sformatf("vec%0d snoozing", i),   {7'd0, bus.snoozing},   8'd0);
      chk($sformatf("vec%0d snooze_cnt", i), {6'd0, bus.snooze_cnt}, 8'd0);
    end

    // Test 2: after stop, 59 more ticks inside 07:30 never re-fire
    for (int i = 0; i < 59; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      chk($sformatf("hold%0d ringing", i), {7'd0, bus.ringing}, 8'd0);
    end

`ifdef ALARM_SNOOZE_EN
    // Test 4: three snoozes of 60 ticks, fourth snooze stops
    retrig("snz start");
    for (int k = 1; k <= 3; k++) begin
      cyc(1'b0, 1'b0, 1'b1);
      chk($sformatf("snz%0d snoozing", k),   {7'd0, bus.snoozing},   8'd1);
      chk($sformatf("snz%0d ringing", k),    {7'd0, bus.ringing},    8'd0);
      chk($sformatf("snz%0d buzzer", k),     {7'd0, bus.buzzer},     8'd0);
      chk($sformatf("snz%0d snooze_cnt", k), {6'd0, bus.snooze_cnt}, k[7:0]);
      if (k == 1) begin
        cyc(1'b0, 1'b0, 1'b1);
        chk("snz ignored cnt",      {6'd0, bus.snooze_cnt}, 8'd1);
        chk("snz ignored snoozing", {7'd0, bus.snoozing},   8'd1);
      end
      for (int j = 0; j < 59; j++) cyc(1'b1, 1'b0, 1'b0);
      chk($sformatf("snz%0d t59 snoozing", k), {7'd0, bus.snoozing}, 8'd1);
      cyc(1'b1, 1'b0, 1'b0);
      chk($sformatf("snz%0d t60 ringing", k),  {7'd0, bus.ringing},  8'd1);
      chk($sformatf("snz%0d t60 snoozing", k), {7'd0, bus.snoozing}, 8'd0);
      chk($sformatf("snz%0d t60 buzzer", k),   {7'd0, bus.buzzer},   8'd1);
    end
    cyc(1'b0, 1'b0, 1'b1);
    chk("snz4 ringing",  {7'd0, bus.ringing},  8'd0);
    chk("snz4 snoozing", {7'd0, bus.snoozing}, 8'd0);
    chk("snz4 buzzer",   {7'd0, bus.buzzer},   8'd0);

    // Stop while snoozing
    retrig("snzstop start");
    cyc(1'b0, 1'b0, 1'b1);
    chk("snzstop enter", {7'd0, bus.snoozing}, 8'd1);
    cyc(1'b0, 1'b1, 1'b0);
    chk("snzstop snoozing", {7'd0, bus.snoozing}, 8'd0);
    chk("snzstop ringing",  {7'd0, bus.ringing},  8'd0);

    // Test 5: alarm_en low mid-snooze clears everything
    retrig("snzen start");
    cyc(1'b0, 1'b0, 1'b1);
    chk("snzen enter", {7'd0, bus.snoozing}, 8'd1);
    bus.alarm_en = 1'b0;
    cyc(1'b1, 1'b0, 1'b0);
    chk("snzen snoozing",   {7'd0, bus.snoozing},   8'd0);
    chk("snzen ringing",    {7'd0, bus.ringing},    8'd0);
    chk("snzen buzzer",     {7'd0, bus.buzzer},     8'd0);
    chk("snzen snooze_cnt", {6'd0, bus.snooze_cnt}, 8'd0);
    bus.alarm_en = 1'b1;
`else
    // Test 6b: without snooze support the snooze button stops the alarm
    retrig("nosnz start");
    cyc(1'b0, 1'b0, 1'b1);
    chk("nosnz ringing",    {7'd0, bus.ringing},    8'd0);
    chk("nosnz snoozing",   {7'd0, bus.snoozing},   8'd0);
    chk("nosnz buzzer",     {7'd0, bus.buzzer},     8'd0);
    chk("nosnz snooze_cnt", {6'd0, bus.snooze_cnt}, 8'd0);
`endif

    // Test 6: reset between edges while ringing takes effect immediately
    retrig("rst start");
    #2 rst = 1'b1;
    #1;
    chk("rst async ringing", {7'd0, bus.ringing}, 8'd0);
    chk("rst async buzzer",  {7'd0, bus.buzzer},  8'd0);
    set_time(16'h0731);
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b1, 1'b0, 1'b0);
    chk("rst after ringing", {7'd0, bus.ringing}, 8'd0);
    set_time(16'h0730);
    cyc(1'b0, 1'b0, 1'b0);
    chk("rst refire ringing", {7'd0, bus.ringing}, 8'd1);
    chk("rst refire buzzer",  {7'd0, bus.buzzer},  8'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
